// File: rtl/sfx_seq.sv
`default_nettype none
// ============================================================================
// Module   : sfx_seq
// Desc     : Priority-arbitrated sound-effect sequencer. A rising edge on a
//            trigger channel plays a square-wave tone built from that
//            channel's half-period and duration, followed by a silent gap.
//            Lower channel indices win arbitration and may preempt a tone
//            that is already playing on a higher index.
// Options  : SFX_QUEUE_EN - remember non-preempting requests seen during
//            PLAY/GAP and serve them from IDLE (default: dropped).
// Revision : 1.0 - initial release
// ============================================================================
module sfx_seq #(
  parameter int NUM_CH  = 4,
  parameter int HP_W    = 18,
  parameter int DUR_W   = 25,
  parameter int GAP_CYC = 1000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       trig,
  input  logic [NUM_CH*HP_W-1:0]  half_period,
  input  logic [NUM_CH*DUR_W-1:0] duration,
  input  logic                    mute,
  output logic                    sound,
  output logic                    busy,
  output logic [CH_W-1:0]         active_ch,
  output logic                    done
);

  // GAP_CYC of 0 still yields a single gap cycle, so the counter never
  // needs to represent more than max(GAP_CYC,1)-1.
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 1) ? GAP_W'(GAP_CYC - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] trig_q, trig_d;
  logic              arm_q, arm_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [HP_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              sound_int_q, sound_int_d;
  logic              sound_q, sound_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
`ifdef SFX_QUEUE_EN
  logic [NUM_CH-1:0] pending_q, pending_d;
`endif

  logic [HP_W-1:0]   hp_arr  [NUM_CH];
  logic [DUR_W-1:0]  dur_arr [NUM_CH];
  logic [NUM_CH-1:0] dur_nz;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] req_v;
  logic [NUM_CH-1:0] cand_v;
  logic [NUM_CH-1:0] sel_oh;
  logic [CH_W-1:0]   sel_idx;
  logic              sel_vld;
  logic              start;
  logic              preempt;
  logic              tone_end;
  logic              gap_end;

  // Unpack the per-channel configuration buses.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hp_arr[i]  = half_period[i*HP_W +: HP_W];
    assign dur_arr[i] = duration[i*DUR_W +: DUR_W];
    assign dur_nz[i]  = |duration[i*DUR_W +: DUR_W];
  end

  // Edge detection and lowest-index arbitration among requests with a
  // nonzero duration; zero-duration requests simply never become candidates.
  always_comb begin
    // Levels already high when reset releases are not treated as new edges.
    rise = arm_q ? (trig & ~trig_q) : '0;
`ifdef SFX_QUEUE_EN
    req_v = (state_q == S_IDLE) ? (rise | pending_q) : rise;
`else
    req_v = rise;
`endif
    cand_v  = req_v & dur_nz;
    sel_vld = |cand_v;
    sel_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cand_v[i]) sel_idx = CH_W'(i);
    end
    start    = (state_q == S_IDLE) && sel_vld;
    preempt  = (state_q == S_PLAY) && sel_vld && (sel_idx < active_ch_q);
    sel_oh   = (start || preempt) ? (NUM_CH'(1) << sel_idx) : '0;
    tone_end = (state_q == S_PLAY) && !preempt && (dur_cnt_q == dur_q - DUR_W'(1));
    gap_end  = (state_q == S_GAP) && (gap_cnt_q == GAP_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PLAY;
      S_PLAY:  if (preempt) state_d = S_PLAY;
               else if (tone_end) state_d = S_GAP;
      S_GAP:   if (gap_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-values: snapshots, tone/duration/gap counters.
  always_comb begin
    trig_d      = trig;
    arm_d       = 1'b1;
    hp_d        = hp_q;
    dur_d       = dur_q;
    tone_cnt_d  = tone_cnt_q;
    dur_cnt_d   = dur_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sound_int_d = sound_int_q;
    active_ch_d = active_ch_q;
    done_d      = tone_end;

    if (start || preempt) begin
      // New tone: take a private copy so later input changes do not leak in.
      hp_d        = hp_arr[sel_idx];
      dur_d       = dur_arr[sel_idx];
      active_ch_d = sel_idx;
      tone_cnt_d  = '0;
      dur_cnt_d   = '0;
      sound_int_d = 1'b0;
    end else if (state_q == S_PLAY) begin
      if (tone_end) begin
        dur_cnt_d   = '0;
        tone_cnt_d  = '0;
        sound_int_d = 1'b0;
        gap_cnt_d   = '0;
      end else begin
        dur_cnt_d = dur_cnt_q + DUR_W'(1);
        // A zero half-period is a rest: the square wave never toggles.
        if (hp_q != '0) begin
          if (tone_cnt_q == hp_q - HP_W'(1)) begin
            tone_cnt_d  = '0;
            sound_int_d = ~sound_int_q;
          end else begin
            tone_cnt_d = tone_cnt_q + HP_W'(1);
          end
        end
      end
    end else if (state_q == S_GAP) begin
      gap_cnt_d = gap_end ? '0 : gap_cnt_q + GAP_W'(1);
    end

    sound_d = sound_int_d & ~mute & (state_d == S_PLAY);

`ifdef SFX_QUEUE_EN
    if (state_q == S_IDLE) pending_d = (pending_q | rise) & dur_nz & ~sel_oh;
    else                   pending_d = pending_q | (rise & ~sel_oh);
`endif
  end

  // Datapath registers; reset silences the speaker at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q      <= '0;
      arm_q       <= 1'b0;
      hp_q        <= '0;
      dur_q       <= '0;
      tone_cnt_q  <= '0;
      dur_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sound_int_q <= 1'b0;
      sound_q     <= 1'b0;
      done_q      <= 1'b0;
      active_ch_q <= '0;
`ifdef SFX_QUEUE_EN
      pending_q   <= '0;
`endif
    end else begin
      trig_q      <= trig_d;
      arm_q       <= arm_d;
      hp_q        <= hp_d;
      dur_q       <= dur_d;
      tone_cnt_q  <= tone_cnt_d;
      dur_cnt_q   <= dur_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sound_int_q <= sound_int_d;
      sound_q     <= sound_d;
      done_q      <= done_d;
      active_ch_q <= active_ch_d;
`ifdef SFX_QUEUE_EN
      pending_q   <= pending_d;
`endif
    end
  end

  assign sound     = sound_q;
  assign busy      = (state_q != S_IDLE);
  assign active_ch = active_ch_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sfx_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfx_seq
// Desc     : Self-checking bench for sfx_seq: directed scenarios followed by
//            random triggers, compared every cycle to a tone-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfx_seq;

  localparam int NUM_CH  = 4;
  localparam int HP_W    = 8;
  localparam int DUR_W   = 10;
  localparam int GAP_CYC = 12;
  localparam int CH_W    = 2;
  localparam int GAP_LEN = (GAP_CYC > 0) ? GAP_CYC : 1;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_GAP  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       trig;
  logic [NUM_CH*HP_W-1:0]  half_period;
  logic [NUM_CH*DUR_W-1:0] duration;
  logic                    mute;
  logic                    sound;
  logic                    busy;
  logic [CH_W-1:0]         active_ch;
  logic                    done;

  int checks   = 0;
  int failures = 0;

  // Tone-level reference state.
  int                m_mode;
  int                m_k;      // cycles elapsed since the current tone began
  int                m_hp;
  int                m_dur;
  int                m_ch;
  int                m_gap;
  logic              m_done;
  logic              m_sound;
  logic              m_armed;
  logic [NUM_CH-1:0] m_prev;
  logic [NUM_CH-1:0] m_pend;

  sfx_seq #(
    .NUM_CH  (NUM_CH),
    .HP_W    (HP_W),
    .DUR_W   (DUR_W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig        (trig),
    .half_period (half_period),
    .duration    (duration),
    .mute        (mute),
    .sound       (sound),
    .busy        (busy),
    .active_ch   (active_ch),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic int hp_of(int i);
    return int'(half_period[i*HP_W +: HP_W]);
  endfunction

  function automatic int dur_of(int i);
    return int'(duration[i*DUR_W +: DUR_W]);
  endfunction

  task automatic set_ch(int ch, int hp, int dur);
    half_period[ch*HP_W +: HP_W] = HP_W'(hp);
    duration[ch*DUR_W +: DUR_W]  = DUR_W'(dur);
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_k     = 0;
    m_hp    = 0;
    m_dur   = 0;
    m_ch    = 0;
    m_gap   = 0;
    m_done  = 1'b0;
    m_sound = 1'b0;
    m_armed = 1'b0;
    m_prev  = '0;
    m_pend  = '0;
  endtask

  task automatic begin_tone(int s);
    m_mode = M_PLAY;
    m_k    = 0;
    m_hp   = hp_of(s);
    m_dur  = dur_of(s);
    m_ch   = s;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] nz;
    int sel;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rise = m_armed ? (trig & ~m_prev) : '0;
    req  = rise;
    nz   = '0;
    for (int i = 0; i < NUM_CH; i++) nz[i] = (dur_of(i) != 0);
`ifdef SFX_QUEUE_EN
    if (m_mode == M_IDLE) req = rise | m_pend;
`endif
    sel = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel < 0 && req[i] && nz[i]) sel = i;
    end
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: begin
`ifdef SFX_QUEUE_EN
        m_pend = (m_pend | rise) & nz;
        if (sel >= 0) m_pend[sel] = 1'b0;
`endif
        if (sel >= 0) begin_tone(sel);
      end
      M_PLAY: begin
        if (sel >= 0 && sel < m_ch) begin
`ifdef SFX_QUEUE_EN
          m_pend = m_pend | rise;
          m_pend[sel] = 1'b0;
`endif
          begin_tone(sel);
        end else begin
`ifdef SFX_QUEUE_EN
          m_pend = m_pend | rise;
`endif
          if (m_k == m_dur - 1) begin
            m_mode = M_GAP;
            m_gap  = 0;
            m_done = 1'b1;
          end else begin
            m_k++;
          end
        end
      end
      default: begin
`ifdef SFX_QUEUE_EN
        m_pend = m_pend | rise;
`endif
        if (m_gap + 1 >= GAP_LEN) m_mode = M_IDLE;
        else m_gap++;
      end
    endcase
    // Square wave: low for the first half-period, then alternating.
    if (m_mode == M_PLAY && m_hp != 0) m_sound = (((m_k / m_hp) % 2) == 1) && !mute;
    else m_sound = 1'b0;
    m_prev  = trig;
    m_armed = 1'b1;
  endtask

  task automatic compare(string tag);
    check({tag, "_busy"},   busy,      (m_mode != M_IDLE));
    check({tag, "_sound"},  sound,     m_sound);
    check({tag, "_done"},   done,      m_done);
    check({tag, "_active"}, active_ch, m_ch);
  endtask

  // One clock: model advances, DUT clocks, outputs checked on the falling edge.
  task automatic cycle(string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare(tag);
  endtask

  task automatic run_idle(int budget, string tag);
    for (int n = 0; n < budget; n++) begin
      cycle(tag);
      if (m_mode == M_IDLE && busy === 1'b0) return;
    end
    check({tag, "_timeout_busy"}, busy, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    trig        = '0;
    half_period = '0;
    duration    = '0;
    mute        = 1'b0;
    model_reset();
    repeat (3) cycle("reset");
    rst_n = 1'b1;
    repeat (3) cycle("idle");

    // Basic tone on channel 2.
    set_ch(2, 10, 100);
    trig[2] = 1'b1;
    cycle("basic_edge");
    check("basic_busy_next", busy, 1);
    run_idle(200, "basic");
    trig = '0;
    cycle("basic_rel");

    // Simultaneous edges on ch1 and ch3.
    set_ch(1, 5, 20);
    set_ch(3, 3, 15);
    trig[1] = 1'b1;
    trig[3] = 1'b1;
    cycle("prio_edge");
    check("prio_active", active_ch, 1);
    run_idle(100, "prio_a");
    cycle("prio_mid");
    run_idle(100, "prio_b");
    trig = '0;
    cycle("prio_rel");

    // Preemption of ch3 by ch0.
    set_ch(3, 4, 200);
    set_ch(0, 6, 30);
    trig[3] = 1'b1;
    cycle("pre_edge3");
    repeat (40) cycle("pre_play3");
    trig[0] = 1'b1;
    cycle("pre_edge0");
    check("pre_active0", active_ch, 0);
    check("pre_sound0", sound, 0);
    run_idle(300, "pre");
    trig = '0;
    cycle("pre_rel");

    // Rest tone and zero-duration request.
    set_ch(0, 0, 50);
    trig[0] = 1'b1;
    cycle("rest_edge");
    run_idle(100, "rest");
    trig = '0;
    cycle("rest_rel");
    set_ch(1, 7, 0);
    trig[1] = 1'b1;
    cycle("zero_edge");
    check("zero_busy", busy, 0);
    cycle("zero_hold");
    trig = '0;
    cycle("zero_rel");

    // Muted tone keeps timing.
    set_ch(2, 3, 40);
    mute    = 1'b1;
    trig[2] = 1'b1;
    cycle("mute_edge");
    run_idle(100, "mute");
    mute = 1'b0;
    trig = '0;
    cycle("mute_rel");

    // Asynchronous reset mid-tone, trigger held through release.
    set_ch(1, 4, 80);
    trig[1] = 1'b1;
    cycle("rst_edge");
    repeat (30) cycle("rst_play");
    check("rst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_sound", sound, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_done", done, 0);
    check("rst_async_active", active_ch, 0);
    model_reset();
    @(negedge clk);
    repeat (2) cycle("rst_hold");
    rst_n = 1'b1;
    repeat (30) cycle("rst_release");
    trig = '0;
    cycle("rst_rel");

    // Random triggers, configuration changes and mute.
    for (int c = 0; c < NUM_CH; c++) set_ch(c, $urandom_range(0, 6), $urandom_range(1, 40));
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 9) == 0) trig[c] = ~trig[c];
      end
      if ($urandom_range(0, 24) == 0)
        set_ch($urandom_range(0, NUM_CH - 1), $urandom_range(0, 6), $urandom_range(0, 40));
      if ($urandom_range(0, 39) == 0) mute = ~mute;
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sfx_seq.md
SFX_SEQ -- requirements
Module: sfx_seq

Interface
REQ-001 Parameter NUM_CH, default 4, number of trigger channels (1..16).
REQ-002 Parameter HP_W, default 18, width of a half-period value in clock cycles.
REQ-003 Parameter DUR_W, default 25, width of a duration value in clock cycles.
REQ-004 Parameter GAP_CYC, default 1000, silent cycles enforced after each tone.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 trig  input  NUM_CH  per-channel event level; a 0->1 transition requests that channel's tone.
REQ-008 half_period  input  NUM_CH*HP_W  packed per-channel half-period, channel i at bits [i*HP_W +: HP_W].
REQ-009 duration  input  NUM_CH*DUR_W  packed per-channel tone length, channel i at bits [i*DUR_W +: DUR_W].
REQ-010 mute  input  1  forces sound to 0 without affecting timing.
REQ-011 sound  output  1  square-wave speaker drive.
REQ-012 busy  output  1  high in PLAY or GAP.
REQ-013 active_ch  output  CH_W  index of the channel playing, or last played; CH_W = max(1, clog2(NUM_CH)).
REQ-014 done  output  1  one-cycle pulse when a tone completes its full duration.

Function
REQ-015 The block SHALL register trig each cycle as trig_q; edge[i] = trig[i] & ~trig_q[i].
REQ-016 The block SHALL have states IDLE, PLAY and GAP.
REQ-017 IDLE: on any edge with a nonzero duration, the block SHALL select the lowest such index, snapshot its half_period and duration, and enter PLAY on the next cycle, so busy=1 one cycle after the edge.
REQ-018 An edge whose channel has duration==0 SHALL be discarded; lower-priority edges in the same cycle SHALL still be considered.
REQ-019 PLAY: dur_cnt SHALL count from 0; at dur_cnt==snapshot_duration-1 the block SHALL pulse done, clear sound and enter GAP.
REQ-020 PLAY: tone_cnt SHALL count from 0; at tone_cnt==snapshot_hp-1 sound_int SHALL toggle and tone_cnt SHALL clear. The first toggle occurs hp cycles after PLAY entry.
REQ-021 snapshot_hp==0 SHALL be a rest: sound held 0 for the full duration; done still pulses.
REQ-022 Preemption: in PLAY, an edge on channel j < active_ch with nonzero duration SHALL restart PLAY for j, with counters and sound cleared, the new snapshot taken, and no done pulse for the aborted tone. Edges on j >= active_ch SHALL be ignored (see REQ-028).
REQ-023 GAP: sound=0; the block SHALL count GAP_CYC cycles, then enter IDLE. GAP_CYC==0 SHALL mean GAP lasts exactly 1 cycle. Edges during GAP SHALL be ignored (see REQ-028).
REQ-024 sound SHALL equal sound_int & ~mute & (state==PLAY), registered.
REQ-025 Later changes to half_period or duration SHALL NOT affect a tone in progress.
REQ-026 All counters SHALL saturate-free wrap only via explicit clear; no arithmetic wider than HP_W/DUR_W.

Reset
REQ-027 While rst_n=0: state=IDLE; sound=0; busy=0; done=0; active_ch=0; trig_q=0; all counters and snapshots=0. Reset mid-tone SHALL silence sound immediately and drop any pending requests.

Configuration
REQ-028 With macro SFX_QUEUE_EN defined, non-preempting edges in PLAY or GAP SHALL set pending[i]. IDLE SHALL arbitrate on edge|pending, clear the served bit on selection, and clear a bit whose duration is 0. Without the macro, such edges SHALL be dropped and no pending register SHALL exist.

Verification
REQ-029 NUM_CH=4, ch2 hp=10, dur=100, edge on trig[2] -> busy rises next cycle; sound toggles every 10 cycles; done pulses at cycle 100 of PLAY; busy falls GAP_CYC later.
REQ-030 Edges on ch1 and ch3 in the same cycle -> active_ch=1; ch3 is lost without SFX_QUEUE_EN and plays after GAP with it.
REQ-031 ch3 playing; edge on ch0 at PLAY cycle 40 -> restart with active_ch=0; no done for ch3; sound=0 on the restart cycle.
REQ-032 ch0 hp=0, dur=50 -> sound stays 0; done pulses after 50 cycles. ch1 dur=0 edge -> busy stays 0.
REQ-033 mute=1 throughout a tone -> sound=0; done and busy timing identical to the unmuted run.
REQ-034 rst_n low at PLAY cycle 30 -> sound=0 and busy=0 asynchronously; trig held high after release produces no tone.
